// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared types and defaults for the fetch sequencer
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2
  } seq_state_t;

  typedef enum logic [1:0] {
    REDIR_NONE   = 2'd0,
    REDIR_BRANCH = 2'd1,
    REDIR_JUMP   = 2'd2,
    REDIR_EXC    = 2'd3
  } redir_src_t;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;

endpackage

// File: rtl/pc_redirect_sel.sv
// rtl/pc_redirect_sel.sv - priority select of redirect source and word-aligned target
module pc_redirect_sel
  import pc_sequencer_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] EXC_VECTOR = DATA_WIDTH'(DEF_EXC_VECTOR)
) (
  input  logic                  exception,
  input  logic                  jump,
  input  logic [DATA_WIDTH-1:0] jump_target,
  input  logic                  branch_taken,
  input  logic [DATA_WIDTH-1:0] branch_target,
  output logic                  redirect,
  output logic [DATA_WIDTH-1:0] target
);

  redir_src_t            src;
  logic [DATA_WIDTH-1:0] raw_target;

  always_comb begin
    src = REDIR_NONE;
    if (exception)         src = REDIR_EXC;
    else if (jump)         src = REDIR_JUMP;
    else if (branch_taken) src = REDIR_BRANCH;
  end

  always_comb begin
    raw_target = '0;
    case (src)
      REDIR_EXC:    raw_target = EXC_VECTOR;
      REDIR_JUMP:   raw_target = jump_target;
      REDIR_BRANCH: raw_target = branch_target;
      default:      raw_target = '0;
    endcase
  end

  assign redirect = (src != REDIR_NONE);
  assign target   = {raw_target[DATA_WIDTH-1:2], 2'b00};

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter and req/ack instruction fetch sequencer
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = DATA_WIDTH'(DEF_RESET_VECTOR),
  parameter logic [DATA_WIDTH-1:0] EXC_VECTOR   = DATA_WIDTH'(DEF_EXC_VECTOR)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [DATA_WIDTH-1:0] branch_target,
  input  logic                  jump,
  input  logic [DATA_WIDTH-1:0] jump_target,
  input  logic                  exception,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] pc_out,
  output logic [DATA_WIDTH-1:0] pc_plus4
);

  seq_state_t            state;
  seq_state_t            state_nxt;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] pc_inc;
  logic                  redir_pend;
  logic [DATA_WIDTH-1:0] redir_tgt;
  logic                  redirect;
  logic [DATA_WIDTH-1:0] redir_target;

  pc_redirect_sel #(
    .DATA_WIDTH (DATA_WIDTH),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_redirect_sel (
    .exception     (exception),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .redirect      (redirect),
    .target        (redir_target)
  );

  assign pc_inc = pc + DATA_WIDTH'(4);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // An ack that lands on a stale fetch keeps us in REQ so the redirect target issues next.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = REQ;
      REQ:     if (imem_ack && !redirect && !redir_pend) state_nxt = VALID;
      VALID:   if (redirect || !stall) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_req  = (state == REQ);
    imem_addr = pc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_VECTOR;
      redir_pend  <= 1'b0;
      redir_tgt   <= '0;
      instr_valid <= 1'b0;
      instr       <= '0;
      pc_out      <= '0;
      pc_plus4    <= DATA_WIDTH'(4);
    end else begin
      case (state)
        REQ: begin
          if (imem_ack) begin
            redir_pend <= 1'b0;
            if (redirect) begin
              pc <= redir_target;
            end else if (redir_pend) begin
              pc <= redir_tgt;
            end else begin
              instr       <= imem_rdata;
              pc_out      <= pc;
              pc_plus4    <= pc_inc;
              pc          <= pc_inc;
              instr_valid <= 1'b1;
            end
          end else if (redirect) begin
            // The fetch address must stay stable until ack, so park the target.
            redir_pend <= 1'b1;
            redir_tgt  <= redir_target;
          end
        end
        VALID: begin
          if (redirect) begin
            instr_valid <= 1'b0;
            pc          <= redir_target;
          end else if (!stall) begin
            instr_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
